cpu_sequencer: RTL and testbench

The sequencer is the microinstruction sequencer for the 8-bit CPU. It steps a T-state counter through fetch and execute and, from the current T-state and the IR opcode, drives the 15-bit control word to the program counter, MAR, RAM, IR, accumulator, B register, ALU and output register. It adds three things on top of plain decoding:
- variable-length instructions;
- a RAM-ready stall handshake;
- run / single-step / halt control from the top level.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cpu_ucode_rom.sv | 66 ++++++
 rtl/cpu_sequencer.sv | 63 ++++++
 tb/tb_cpu_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, control-bit indices and sequencer states for the 8-bit CPU
package cpu_pkg;

    localparam int CW = 15;
    typedef logic [CW-1:0] cword_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_OUT = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CP  = 14;
    localparam int EP  = 13;
    localparam int LP  = 12;
    localparam int LM  = 11;
    localparam int CE  = 10;
    localparam int LI  = 9;
    localparam int EI  = 8;
    localparam int LA  = 7;
    localparam int EA  = 6;
    localparam int SU  = 5;
    localparam int EU  = 4;
    localparam int LB  = 3;
    localparam int LO  = 2;
    localparam int HLT = 1;

    // T-states are numbered so that tstate = state - 1 while busy
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

    function automatic cword_t cb(input int i);
        return cword_t'(1) << i;
    endfunction

endpackage

// File: rtl/cpu_ucode_rom.sv
// cpu_ucode_rom: combinational microcode lookup from T-state and opcode
module cpu_ucode_rom
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [2:0]          tstate,
    input  logic [OPCODE_W-1:0] opcode,
    output cword_t              word,
    output logic                last,
    output logic                uses_mem,
    output logic                illegal
);

    logic [3:0] op;
    assign op = 4'(opcode);
    assign uses_mem = word[CE];

    // fetch is opcode-independent; execute words and the end-of-instruction flag come from the opcode
    always_comb begin
        word = '0;
        last = 1'b0;
        illegal = 1'b0;
        case (tstate)
            3'd0: word = cb(EP) | cb(LM);
            3'd1: word = cb(CP);
            3'd2: word = cb(CE) | cb(LI);
            3'd3: begin
                case (op)
                    OP_NOP: last = 1'b1;
                    OP_LDA, OP_ADD, OP_SUB: word = cb(EI) | cb(LM);
                    OP_OUT: begin
                        word = cb(EA) | cb(LO);
                        last = 1'b1;
                    end
                    OP_JMP: begin
                        word = cb(EI) | cb(LP);
                        last = 1'b1;
                    end
                    OP_LDI: begin
                        word = cb(EI) | cb(LA);
                        last = 1'b1;
                    end
                    OP_HLT: begin
                        word = cb(HLT);
                        last = 1'b1;
                    end
                    default: begin
                        last = 1'b1;
                        illegal = 1'b1;
                    end
                endcase
            end
            3'd4: begin
                word = cb(CE) | (op == OP_LDA ? cb(LA) : cb(LB));
                last = op == OP_LDA;
            end
            3'd5: begin
                word = cb(EU) | cb(LA) | (op == OP_SUB ? cb(SU) : cword_t'(0));
                last = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: T-state FSM with run/step/halt control and RAM-ready stalls
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CTRL_W   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [2:0]          tstate,
    output logic                busy,
    output logic                halted,
    output logic                instr_done,
    output logic                illegal
);

    state_t state;
    cword_t word;
    logic   last;
    logic   uses_mem;
    logic   ill;
    logic   active;
    logic   stall;

    assign active = state != IDLE && state != HALT;
    assign tstate = active ? 3'(state) - 3'd1 : 3'd0;
    assign stall  = active && uses_mem && !mem_ready;

    cpu_ucode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
        .tstate   (tstate),
        .opcode   (opcode),
        .word     (word),
        .last     (last),
        .uses_mem (uses_mem),
        .illegal  (ill)
    );

    // a stalled read keeps only the RAM enable so nothing latches stale bus data
    always_comb begin
        ctrl       = rst || !active ? '0 : stall ? CTRL_W'(cb(CE)) : CTRL_W'(word);
        busy       = active;
        halted     = state == HALT;
        instr_done = active && last && !stall;
        illegal    = active && ill;
    end

    // advance through T-states; HLT parks in HALT until reset, otherwise loop or idle on run
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (state == IDLE) begin
            if (run || step)
                state <= T0;
        end else if (active && !stall)
            state <= word[HLT] ? HALT : last ? (run ? T0 : IDLE) : state_t'(state + 3'd1);
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed-vector bench for the microinstruction sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        mem_ready = 1'b1;
    logic [14:0] ctrl;
    logic [2:0]  tstate;
    logic        busy;
    logic        halted;
    logic        instr_done;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    logic [14:0] add_seq [6] = '{15'h2800, 15'h4000, 15'h0600, 15'h0900, 15'h0408, 15'h0090};

    cpu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .ctrl       (ctrl),
        .tstate     (tstate),
        .busy       (busy),
        .halted     (halted),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_ctrl"}, 16'(ctrl), 16'h0);
        check({tag, "_tstate"}, 16'(tstate), 16'h0);
        check({tag, "_busy"}, 16'(busy), 16'h0);
        check({tag, "_halted"}, 16'(halted), 16'h0);
        check({tag, "_done"}, 16'(instr_done), 16'h0);
        check({tag, "_illegal"}, 16'(illegal), 16'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 check("rst_ctrl", 16'(ctrl), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 idle_outputs("reset");

        // free-running ADD, back-to-back into the next T0
        @(negedge clk);
        run = 1'b1;
        opcode = 4'h2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("add_ctrl%0d", i), 16'(ctrl), 16'(add_seq[i]));
            check($sformatf("add_ts%0d", i), 16'(tstate), 16'(i));
            check($sformatf("add_done%0d", i), 16'(instr_done), 16'(i == 5));
        end
        @(negedge clk);
        run = 1'b0;
        #1;
        check("b2b_tstate", 16'(tstate), 16'h0);
        check("b2b_busy", 16'(busy), 16'h1);
        check("b2b_ctrl", 16'(ctrl), 16'h2800);
        repeat (5) @(negedge clk);
        #1 check("add_late_done", 16'(instr_done), 16'h1);
        @(negedge clk);
        #1 idle_outputs("run_drop");

        // single step LDI
        @(negedge clk);
        opcode = 4'h6;
        step = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            step = 1'b0;
            #1;
            check($sformatf("ldi_busy%0d", i), 16'(busy), 16'h1);
            check($sformatf("ldi_done%0d", i), 16'(instr_done), 16'(i == 3));
        end
        check("ldi_t3_ctrl", 16'(ctrl), 16'h0180);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check($sformatf("step_idle%0d", i), 16'(busy), 16'h0);
        end
        check("step_idle_ts", 16'(tstate), 16'h0);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        #1 check("step2_busy", 16'(busy), 16'h1);
        repeat (4) @(negedge clk);
        #1 check("step2_idle", 16'(busy), 16'h0);

        // LDA with three stall cycles at T4
        @(negedge clk);
        opcode = 4'h1;
        step = 1'b1;
        repeat (4) begin
            @(negedge clk);
            step = 1'b0;
        end
        #1 check("lda_t3_ctrl", 16'(ctrl), 16'h0900);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check($sformatf("stall_ctrl%0d", i), 16'(ctrl), 16'h0400);
            check($sformatf("stall_ts%0d", i), 16'(tstate), 16'h4);
            check($sformatf("stall_done%0d", i), 16'(instr_done), 16'h0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("lda_t4_ctrl", 16'(ctrl), 16'h0480);
        check("lda_done", 16'(instr_done), 16'h1);
        @(negedge clk);
        #1 check("lda_idle", 16'(busy), 16'h0);

        // undefined opcode behaves as NOP with an illegal pulse
        @(negedge clk);
        opcode = 4'h9;
        step = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            step = 1'b0;
            #1;
            check($sformatf("ill_pulse%0d", i), 16'(illegal), 16'(i == 3));
            check($sformatf("ill_done%0d", i), 16'(instr_done), 16'(i == 3));
        end
        check("ill_t3_ctrl", 16'(ctrl), 16'h0);
        @(negedge clk);
        #1 check("ill_idle", 16'(busy), 16'h0);

        // HLT parks until reset
        @(negedge clk);
        opcode = 4'hF;
        step = 1'b1;
        repeat (4) begin
            @(negedge clk);
            step = 1'b0;
        end
        #1 check("hlt_ctrl", 16'(ctrl), 16'h0002);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run = i[0];
            step = ~i[0];
            #1;
            check($sformatf("halt_flag%0d", i), 16'(halted), 16'h1);
            check($sformatf("halt_busy%0d", i), 16'(busy), 16'h0);
            check($sformatf("halt_ctrl%0d", i), 16'(ctrl), 16'h0);
        end
        @(negedge clk);
        run = 1'b0;
        step = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 idle_outputs("halt_rst");

        // step coincident with reset is dropped
        @(negedge clk);
        rst = 1'b1;
        step = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step = 1'b0;
        #1 check("rst_step_busy", 16'(busy), 16'h0);

        // reset during an ADD stall at T4
        @(negedge clk);
        opcode = 4'h2;
        run = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("add_stall_ctrl", 16'(ctrl), 16'h0400);
        check("add_stall_ts", 16'(tstate), 16'h4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_stall_ctrl", 16'(ctrl), 16'h0);
        check("rst_stall_ts", 16'(tstate), 16'h4);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        mem_ready = 1'b1;
        #1 idle_outputs("stall_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
